// File: rtl/sar_pkg.sv
// sar_pkg: state encoding and timer width helper for the SAR sequencer
package sar_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_e;
  function automatic int timer_w(int s, int t);
    return (s > t ? s : t) > 1 ? $clog2(s > t ? s : t) : 1;
  endfunction
endpackage

// File: rtl/sar_timer.sv
// sar_timer: loadable down-counter with zero flag, shared by the track and settle windows
module sar_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero = cnt_q == '0;
  always_comb cnt_d = load ? load_val : (zero ? cnt_q : cnt_q - W'(1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sar_sequencer.sv
// sar_sequencer: successive-approximation controller driving track/hold and the trial DAC code
module sar_sequencer import sar_pkg::*; #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             valid
);
  localparam int TW = timer_w(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int IW = $clog2(NBITS);
  state_e state_q, state_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [NBITS-1:0] code_q, code_d, result_q, result_d, kept;
  logic sample_q, sample_d, busy_q, busy_d, valid_q, valid_d;
  logic t_load, t_zero;
  logic [TW-1:0] t_val;
  sar_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    code_d   = code_q;
    result_d = result_q;
    t_load   = 1'b0;
    t_val    = TW'(SETTLE_CYCLES - 1);
    kept     = cmp ? code_q : code_q & ~(NBITS'(1) << bit_q);
    case (state_q)
      IDLE: if (start) begin
        state_d = SAMPLE;
        t_load  = 1'b1;
        t_val   = TW'(SAMPLE_CYCLES - 1);
      end
      SAMPLE: if (abort) state_d = IDLE;
      else if (t_zero) begin
        state_d = CONVERT;
        bit_d   = IW'(NBITS - 1);
        code_d  = NBITS'(1) << (NBITS - 1);
        t_load  = 1'b1;
      end
      CONVERT: if (abort) begin
        state_d = IDLE;
        code_d  = '0;
      end else if (t_zero) begin
        // bit 0 decided: the kept code is the conversion result
        if (bit_q == '0) begin
          state_d  = DONE;
          code_d   = kept;
          result_d = kept;
        end else begin
          bit_d  = bit_q - IW'(1);
          code_d = kept | (NBITS'(1) << (bit_q - IW'(1)));
          t_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = '0;
      end
    endcase
    sample_d = state_d == SAMPLE;
    busy_d   = state_d != IDLE;
    valid_d  = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      result_q <= result_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  assign sample   = sample_q;
  assign dac_code = code_q;
  assign busy     = busy_q;
  assign result   = result_q;
  assign valid    = valid_q;
endmodule

// File: tb/tb_sar_sequencer.sv
// tb_sar_sequencer: cycle-indexed reference model plus directed conversions on two parameterisations
module tb_sar_sequencer;
  typedef struct packed {logic sample; logic busy; logic valid; logic [7:0] dac;} exp_t;
  logic clk = 0, reset = 1;
  logic start_a = 0, abort_a = 0, cmp_a, sample_a, busy_a, valid_a;
  logic start_b = 0, abort_b = 0, cmp_b, sample_b, busy_b, valid_b;
  logic [7:0] dac_a, res_a, dac_b, res_b, vin_a = 0, vin_b = 0;
  int checks = 0, errors = 0;
  int k_a = 0, k_b = 0;
  logic [7:0] mres_a = 0, mres_b = 0;
  logic cs [0:31], cb [0:31], cv [0:31];
  logic [7:0] cd [0:31], cr [0:31];
  logic [7:0] t1 [0:7];
  int nv;

  always #5 clk = ~clk;
  assign cmp_a = vin_a >= dac_a;
  assign cmp_b = vin_b >= dac_b;

  sar_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .cmp(cmp_a),
    .sample(sample_a), .dac_code(dac_a), .busy(busy_a), .result(res_a), .valid(valid_a)
  );
  sar_sequencer #(.NBITS(8), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .cmp(cmp_b),
    .sample(sample_b), .dac_code(dac_b), .busy(busy_b), .result(res_b), .valid(valid_b)
  );

  // k = cycles since the accepting start edge (0 = idle); DONE is cycle s+8t+1
  function automatic int next_k(int k, logic st, logic ab, int s, int t);
    if (k == 0) return st ? 1 : 0;
    if (k == s + 8 * t + 1) return 0;
    if (ab) return 0;
    return k + 1;
  endfunction

  function automatic exp_t model_out(int k, logic [7:0] v, int s, int t);
    exp_t e;
    int i;
    e = '0;
    if (k >= 1 && k <= s) begin
      e.sample = 1'b1;
      e.busy   = 1'b1;
    end else if (k > s && k <= s + 8 * t) begin
      i      = 7 - (k - s - 1) / t;
      e.busy = 1'b1;
      e.dac  = (v & (8'hFF << (i + 1))) | (8'd1 << i);
    end else if (k == s + 8 * t + 1) begin
      e.busy  = 1'b1;
      e.valid = 1'b1;
      e.dac   = v;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  task automatic cmp_inst(input string tag, input int k, input logic [7:0] v, input int s, input int t,
                          input logic smp, input logic bsy, input logic vld, input logic [7:0] dac,
                          input logic [7:0] res, input logic [7:0] mres);
    exp_t e;
    e = model_out(k, v, s, t);
    chk({tag, "_sample"}, smp, e.sample);
    chk({tag, "_busy"}, bsy, e.busy);
    chk({tag, "_valid"}, vld, e.valid);
    chk({tag, "_dac"}, dac, e.dac);
    chk({tag, "_result"}, res, mres);
  endtask

  always @(posedge clk or negedge reset)
    if (!reset) begin
      k_a <= 0; mres_a <= 0; k_b <= 0; mres_b <= 0;
    end else begin
      k_a <= next_k(k_a, start_a, abort_a, 2, 1);
      k_b <= next_k(k_b, start_b, abort_b, 1, 3);
      if (next_k(k_a, start_a, abort_a, 2, 1) == 11) mres_a <= vin_a;
      if (next_k(k_b, start_b, abort_b, 1, 3) == 26) mres_b <= vin_b;
    end

  always @(posedge clk) begin
    #1;
    cmp_inst("a", k_a, vin_a, 2, 1, sample_a, busy_a, valid_a, dac_a, res_a, mres_a);
    cmp_inst("b", k_b, vin_b, 1, 3, sample_b, busy_b, valid_b, dac_b, res_b, mres_b);
  end

  task automatic conv(input bit sel, input logic [7:0] v, input int n, input bit hold);
    @(negedge clk);
    if (sel) begin vin_b = v; start_b = 1; end
    else begin vin_a = v; start_a = 1; end
    for (int j = 1; j <= n; j++) begin
      @(posedge clk); #2;
      if (!hold) begin start_a = 0; start_b = 0; abort_a = 0; end
      cs[j] = sel ? sample_b : sample_a;
      cb[j] = sel ? busy_b : busy_a;
      cv[j] = sel ? valid_b : valid_a;
      cd[j] = sel ? dac_b : dac_a;
      cr[j] = sel ? res_b : res_a;
    end
  endtask

  initial begin
    t1 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    #1 reset = 0;
    #1;
    chk("rst_sample", sample_a, 0); chk("rst_dac", dac_a, 0); chk("rst_busy", busy_a, 0);
    chk("rst_result", res_a, 0); chk("rst_valid", valid_a, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    // Vin=0xA5 with default timing
    conv(0, 8'hA5, 12, 0);
    chk("a5_s1", cs[1], 1); chk("a5_s2", cs[2], 1); chk("a5_s3", cs[3], 0);
    for (int j = 0; j < 8; j++) chk($sformatf("a5_dac%0d", j), cd[3 + j], t1[j]);
    chk("a5_v10", cv[10], 0); chk("a5_v11", cv[11], 1); chk("a5_r11", cr[11], 8'hA5);
    chk("a5_dac12", cd[12], 0); chk("a5_busy12", cb[12], 0);
    conv(0, 8'hFF, 12, 0);
    chk("ff_r11", cr[11], 8'hFF); chk("ff_v11", cv[11], 1);
    conv(0, 8'h00, 12, 0);
    for (int j = 0; j < 8; j++) chk($sformatf("zero_dac%0d", j), cd[3 + j], 8'h80 >> j);
    chk("zero_r11", cr[11], 8'h00); chk("zero_v11", cv[11], 1);
    // start held high: second conversion only after IDLE is re-entered
    conv(0, 8'h33, 24, 1);
    start_a = 0;
    nv = 0;
    for (int j = 1; j <= 24; j++) nv += int'(cv[j]);
    chk("hold_valid_count", nv, 2);
    chk("hold_v11", cv[11], 1); chk("hold_busy12", cb[12], 0);
    chk("hold_s12", cs[12], 0); chk("hold_s13", cs[13], 1);
    chk("hold_v23", cv[23], 1); chk("hold_r23", cr[23], 8'h33);
    for (int i = 0; i < 40 && busy_a; i++) begin @(posedge clk); #2; end
    chk("hold_drain", busy_a, 0);
    // abort during bit 4
    conv(0, 8'hA5, 12, 0);
    conv(0, 8'h3C, 6, 0);
    chk("abort_bit4_dac", cd[6], 8'h30);
    abort_a = 1;
    @(posedge clk); #2;
    abort_a = 0;
    chk("abort_busy", busy_a, 0); chk("abort_dac", dac_a, 0); chk("abort_sample", sample_a, 0);
    chk("abort_valid", valid_a, 0); chk("abort_result", res_a, 8'hA5);
    repeat (3) @(posedge clk);
    // start and abort together in IDLE: start wins
    abort_a = 1;
    conv(0, 8'hC3, 12, 0);
    chk("sa_s1", cs[1], 1); chk("sa_r11", cr[11], 8'hC3);
    // async reset mid-CONVERT
    conv(0, 8'h77, 5, 0);
    #2 reset = 0;
    #1;
    chk("arst_sample", sample_a, 0); chk("arst_dac", dac_a, 0); chk("arst_busy", busy_a, 0);
    chk("arst_valid", valid_a, 0); chk("arst_result", res_a, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    conv(0, 8'h5A, 12, 0);
    chk("post_rst_v11", cv[11], 1); chk("post_rst_r11", cr[11], 8'h5A);
    // SETTLE_CYCLES=3, SAMPLE_CYCLES=1
    conv(1, 8'h96, 27, 0);
    chk("b_s1", cs[1], 1); chk("b_s2", cs[2], 0);
    chk("b_dac2", cd[2], 8'h80); chk("b_dac3", cd[3], 8'h80); chk("b_dac4", cd[4], 8'h80);
    chk("b_dac5", cd[5], 8'hC0); chk("b_dac8", cd[8], 8'hA0);
    chk("b_v25", cv[25], 0); chk("b_v26", cv[26], 1); chk("b_r26", cr[26], 8'h96);
    chk("b_busy27", cb[27], 0);
    repeat (2) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
